// File: rtl/pixel_beat_packer_if.sv
// Pixel-side and beat-side handshake bundles for the pixel beat packer.
// Pixel bundle: source (master) drives r/g/b/valid/sof/eol; packer (slave) returns ready.
interface pixel_beat_packer_pix_if #(
    parameter int COMP_W = 8
);
    logic [COMP_W-1:0] r;
    logic [COMP_W-1:0] g;
    logic [COMP_W-1:0] b;
    logic              valid;
    logic              sof;
    logic              eol;
    logic              ready;

    modport master (output r, g, b, valid, sof, eol, input ready);
    modport slave  (input r, g, b, valid, sof, eol, output ready);
endinterface

interface pixel_beat_packer_axis_if #(
    parameter int PPB = 2
);
    logic [32*PPB-1:0] tdata;
    logic [4*PPB-1:0]  tkeep;
    logic              tlast;
    logic              tuser;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/pixel_beat_packer.sv
// Generic synchronous FIFO: stores W-bit words, head word visible combinationally.
// Latency: pushed word visible at head one cycle later; pop ignored when empty.
// Backpressure: caller must not push when full.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [W-1:0]               head_dat,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Packs 1 pixel/cycle into PPB-lane beats with tkeep holes at end of line, buffered in a beat FIFO.
// Latency: beat visible on tvalid the cycle after its completing pixel is accepted (empty FIFO).
// Backpressure: ready from registered state only; with FIFO full a partial beat may still fill until its last lane.
module pixel_beat_packer #(
    parameter int COMP_W     = 8,
    parameter int PPB        = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     aclk,
    input  logic                     areset,
    pixel_beat_packer_pix_if.slave   pix,
    pixel_beat_packer_axis_if.master axis,
    output logic                     resync
);
    localparam int LW = (PPB > 1) ? $clog2(PPB) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(PPB - 1);

    typedef struct packed {
        logic [32*PPB-1:0] data;
        logic [4*PPB-1:0]  keep;
        logic              last;
        logic              user;
    } beat_t;

    beat_t                     asm_q;
    beat_t                     asm_nxt;
    beat_t                     push_dat;
    beat_t                     head_dat;
    logic [LW-1:0]             lane_idx;
    logic [LW-1:0]             eff_lane;
    logic                      pend_q;
    logic                      resync_q;
    logic [31:0]               lane_pix;
    logic                      misplaced;
    logic                      completes;
    logic                      in_rdy;
    logic                      fire;
    logic                      push;
    logic                      pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    // A completed beat that finds the FIFO full parks in the assembly register (pend_q).
    assign in_rdy = !areset && !pend_q && (!fifo_full || (lane_idx != LAST_LANE));
    assign fire   = pix.valid && in_rdy;

    always_comb begin
        lane_pix  = 32'({pix.r, pix.g, pix.b});
        misplaced = pix.sof && (lane_idx != '0);
        eff_lane  = misplaced ? '0 : lane_idx;
        asm_nxt   = misplaced ? '0 : asm_q;
        for (int k = 0; k < PPB; k++) begin
            if (eff_lane == LW'(k)) begin
                asm_nxt.data[32*k +: 32] = lane_pix;
                asm_nxt.keep[4*k +: 4]   = 4'hF;
            end
        end
        asm_nxt.last = asm_q.last && !misplaced || pix.eol;
        if (eff_lane == '0) asm_nxt.user = pix.sof;
        completes = (eff_lane == LAST_LANE) || pix.eol;
    end

    assign push     = !fifo_full && (pend_q || (fire && completes));
    assign push_dat = pend_q ? asm_q : asm_nxt;
    assign pop      = axis.tvalid && axis.tready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            asm_q    <= '0;
            lane_idx <= '0;
            pend_q   <= 1'b0;
            resync_q <= 1'b0;
        end else begin
            resync_q <= fire && misplaced;
            if (pend_q) begin
                if (!fifo_full) begin
                    pend_q <= 1'b0;
                    asm_q  <= '0;
                end
            end else if (fire) begin
                if (completes) begin
                    lane_idx <= '0;
                    if (fifo_full) begin
                        asm_q  <= asm_nxt;
                        pend_q <= 1'b1;
                    end else begin
                        asm_q  <= '0;
                    end
                end else begin
                    asm_q    <= asm_nxt;
                    lane_idx <= eff_lane + 1'b1;
                end
            end
        end
    end

    sync_fifo #(
        .W     ($bits(beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (aclk),
        .rst      (areset),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Everything is forced low while reset is held, independent of register contents.
    assign pix.ready   = in_rdy;
    assign axis.tvalid = !areset && !fifo_empty;
    assign axis.tdata  = areset ? '0 : head_dat.data;
    assign axis.tkeep  = areset ? '0 : head_dat.keep;
    assign axis.tlast  = !areset && head_dat.last;
    assign axis.tuser  = !areset && head_dat.user;
    assign resync      = !areset && resync_q;

endmodule
